// File: rtl/compensation_merge.sv
// Adds a per-tile compensation sum to each column partial sum, then rounds,
// shifts, optionally ReLU-clips and saturates; results drain through a small FIFO.
module compensation_merge #(
  parameter int SUM_W    = 33,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 8,
  parameter int TILE_LEN = 8,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             comp_valid,
  input  logic [SUM_W-1:0] comp_sum,
  input  logic             psum_valid,
  input  logic [SUM_W-1:0] psum,
  output logic             psum_ready,
  input  logic             relu_en,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             tile_done,
  output logic             err
);

  // state | meaning
  // IDLE  | waiting for the tile's compensation sum
  // RUN   | accepting TILE_LEN partial sums
  // DRAIN | all psums taken, waiting for pipeline and FIFO to empty
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int CNT_W = $clog2(TILE_LEN + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic signed [SUM_W+1:0] HALF = (SUM_W + 2)'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W+1:0] MAXV = {{(SUM_W + 3 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W+1:0] MINV = {{(SUM_W + 3 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [1:0]       state;
  logic [SUM_W-1:0] comp_reg;
  logic [CNT_W-1:0] cnt;

  logic             s1_valid;
  logic             s1_relu;
  logic [SUM_W:0]   s1_sum;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;

  logic accept;
  logic push;
  logic pop;
  logic drained;

  logic signed [SUM_W+1:0] rnd;
  logic signed [SUM_W+1:0] shr;
  logic [OUT_W-1:0]        res;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stage-1 result counts against capacity so a full FIFO can never be overrun.
  assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, s1_valid};
  assign psum_ready = (state == RUN) && (pending < (OCC_W + 1)'(DEPTH));
  assign accept     = psum_valid && psum_ready;
  assign push       = s1_valid;
  assign out_valid  = (occ != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign drained    = !s1_valid && (occ == '0);
  assign tile_done  = (state == DRAIN) && drained;

  always_comb begin
    rnd = $signed({s1_sum[SUM_W], s1_sum}) + HALF;
    shr = rnd >>> SHIFT;
    if (s1_relu && (shr < 0)) shr = '0;
    if (shr > MAXV)      res = MAXV[OUT_W-1:0];
    else if (shr < MINV) res = MINV[OUT_W-1:0];
    else                 res = shr[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      comp_reg <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (comp_valid) begin
            comp_reg <= comp_sum;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (comp_valid) err <= 1'b1;
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(TILE_LEN - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The done cycle behaves as IDLE for capturing the next tile's comp.
          if (drained) begin
            if (comp_valid) begin
              comp_reg <= comp_sum;
              cnt      <= '0;
              state    <= RUN;
            end else begin
              state <= IDLE;
            end
          end else if (comp_valid) begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_relu  <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_relu <= relu_en;
        s1_sum  <= {psum[SUM_W-1], psum} + {comp_reg[SUM_W-1], comp_reg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_compensation_merge.sv
// Directed bench for compensation_merge: expected results are queued when a psum
// is accepted and a negedge monitor checks every popped FIFO head against them.
module tb_compensation_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        comp_valid;
  logic [32:0] comp_sum;
  logic        psum_valid;
  logic [32:0] psum;
  logic        psum_ready;
  logic        relu_en;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        tile_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  compensation_merge dut (
    .clk(clk), .rst(rst),
    .comp_valid(comp_valid), .comp_sum(comp_sum),
    .psum_valid(psum_valid), .psum(psum), .psum_ready(psum_ready),
    .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tile_done(tile_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready now.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic give_comp(input logic [32:0] c);
    @(negedge clk);
    comp_valid = 1'b1;
    comp_sum   = c;
    @(negedge clk);
    comp_valid = 1'b0;
  endtask

  // Returns just after the accepting edge with psum_valid still high.
  task automatic send(input logic [32:0] p, input logic r, input int e);
    int n = 0;
    @(negedge clk);
    psum_valid = 1'b1;
    psum       = p;
    relu_en    = r;
    while (!psum_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!psum_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got psum_ready=0 expected 1");
    end else begin
      exp_q.push_back(16'(e));
      @(posedge clk);
    end
  endtask

  task automatic stop_psum();
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      #2;
      if (tile_done) break;
      n++;
    end
    chk("tile_done_seen", 64'(tile_done), 64'(1));
    chk("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    #2;
    chk("tile_done_single", 64'(tile_done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; comp_valid = 1'b0; comp_sum = '0;
    psum_valid = 1'b0; psum = '0; relu_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_psum_ready", 64'(psum_ready), 64'(0));
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_out_data",   64'(out_data),   64'(0));
    chk("rst_tile_done",  64'(tile_done),  64'(0));
    chk("rst_err",        64'(err),        64'(0));
    rst = 1'b1;

    // Basic tile: (512 + 256 + 128) >> 8 = 3, with latency check on the first.
    give_comp(33'd256);
    send(33'd512, 1'b0, 3);
    @(negedge clk);
    psum_valid = 1'b0;
    chk("latency_k_plus_half", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("latency_k_plus_1", 64'(out_valid), 64'(1));
    for (int i = 0; i < 7; i++) send(33'd512, 1'b0, 3);
    stop_psum();
    wait_done();

    // Rounding, ReLU and saturation with comp = 0.
    give_comp(33'd0);
    send(-33'sd1000,      1'b0, -4);
    send(-33'sd1000,      1'b1, 0);
    send(33'd127,         1'b0, 0);
    send(33'd128,         1'b0, 1);
    send(33'h0_FFFF_FFFF, 1'b0, 32767);
    send(33'h1_0000_0000, 1'b0, -32768);
    send(33'd383,         1'b0, 1);
    send(-33'sd129,       1'b0, -1);
    stop_psum();
    wait_done();

    // Large comp: sums exceed 33 bits on the positive side.
    give_comp(33'h0_FFFF_FFFF);
    send(33'h0_FFFF_FFFF, 1'b0, 32767);
    send(33'h1_0000_0000, 1'b0, 0);
    send(33'h1_0000_0100, 1'b0, 1);
    send(33'd0,           1'b0, 32767);
    for (int i = 0; i < 4; i++) send(33'h1_0000_0000, 1'b1, 0);
    stop_psum();
    wait_done();

    // Backpressure: only DEPTH psums fit while the consumer stalls.
    out_ready = 1'b0;
    give_comp(33'd0);
    for (int i = 0; i < 4; i++) send(33'(i * 256), 1'b0, i);
    @(negedge clk);
    psum = 33'(4 * 256);
    chk("bp_ready_low_1", 64'(psum_ready), 64'(0));
    repeat (3) @(negedge clk);
    chk("bp_ready_low_2", 64'(psum_ready), 64'(0));
    chk("bp_queue_depth", 64'(exp_q.size()), 64'(4));
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(33'(i * 256), 1'b0, i);
    stop_psum();
    wait_done();

    // Second comp during RUN is ignored but flags err, which stays sticky.
    give_comp(33'd256);
    send(33'd512, 1'b0, 3);
    send(33'd512, 1'b0, 3);
    stop_psum();
    give_comp(33'h0_0010_0000);
    chk("err_set", 64'(err), 64'(1));
    for (int i = 0; i < 6; i++) send(33'd512, 1'b0, 3);
    stop_psum();
    wait_done();
    chk("err_sticky", 64'(err), 64'(1));

    // Reset mid-tile with data in flight.
    out_ready = 1'b0;
    give_comp(33'd256);
    for (int i = 0; i < 3; i++) send(33'd512, 1'b0, 3);
    @(negedge clk);
    psum_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    chk("mid_rst_out_valid",  64'(out_valid),  64'(0));
    chk("mid_rst_psum_ready", 64'(psum_ready), 64'(0));
    chk("mid_rst_out_data",   64'(out_data),   64'(0));
    chk("mid_rst_err",        64'(err),        64'(0));
    @(negedge clk);
    chk("mid_rst_idle", 64'(psum_ready), 64'(0));
    out_ready = 1'b1;

    // Fresh tile with negative comp: (i*256 - 256 + 128) >>> 8 = i - 1.
    @(negedge clk);
    comp_valid = 1'b1;
    comp_sum   = -33'sd256;
    psum_valid = 1'b1;
    psum       = 33'd0;
    chk("comp_cycle_not_ready", 64'(psum_ready), 64'(0));
    @(negedge clk);
    comp_valid = 1'b0;
    psum_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(33'(i * 256), 1'b0, i - 1);
    stop_psum();
    wait_done();
    chk("final_err_clear", 64'(err), 64'(0));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
